// File: rtl/ripple_step_ctrl_pkg.sv
// Shared definitions for the ripple counter step controller.
// State encoding and default timing values live here.
package ripple_step_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_PULSE  = 3'd2,
    ST_SETTLE = 3'd3,
    ST_CHECK  = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  localparam int DEF_SETTLE_CYC = 2;
  localparam int DEF_CLR_CYC    = 2;
  localparam int WAIT_W         = 4;

endpackage

// File: rtl/ripple_step_wait.sv
// Loadable 4-bit down-counter with zero flag.
// Times the CLEAR and SETTLE intervals of the step controller;
// saturates at zero until reloaded.
module ripple_step_wait
  import ripple_step_ctrl_pkg::*;
(
  input  logic              Ck,
  input  logic              reset_,
  input  logic              load,
  input  logic [WAIT_W-1:0] load_val,
  output logic [WAIT_W-1:0] count,
  output logic              zero
);

  // Reload on request, otherwise count down and hold at zero.
  always_ff @(posedge Ck or negedge reset_) begin
    if (!reset_) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/ripple_step_ctrl.sv
// Sequencing controller for a W-bit negedge-T-flop ripple counter.
// Clears the counter, steps it one count at a time, waits for the
// ripple to settle and stops at the requested terminal count.
// Optional macro RIPPLE_STEP_CTRL_SHADOW_CHECK_EN: when defined, every
// CHECK visit compares q against the step count and aborts with err on
// the first mismatch.
// CLEAR holds cnt_clr_ low for CLR_CYC cycles; when steps follow, one
// extra CLEAR cycle with cnt_clr_ released gives the counter reset
// recovery before the first T pulse.
module ripple_step_ctrl
  import ripple_step_ctrl_pkg::*;
#(
  parameter int W          = 4,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int CLR_CYC    = DEF_CLR_CYC
) (
  input  logic         Ck,
  input  logic         reset_,
  input  logic         start,
  input  logic [W-1:0] tc,
  input  logic         ack,
  input  logic [W-1:0] q,
  output logic         t_en,
  output logic         cnt_clr_,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [W-1:0] count_out
);

  localparam logic [WAIT_W-1:0] SETTLE_LD = WAIT_W'(SETTLE_CYC);
  localparam logic [WAIT_W-1:0] CLR_LD    = WAIT_W'(CLR_CYC);

  state_t              state, state_d;
  logic [W-1:0]        tc_q;
  logic [W-1:0]        step;
  logic                wait_load;
  logic [WAIT_W-1:0]   wait_val;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                wait_zero;
  logic                cnt_clr_d;
  logic                finish;
  logic                err_set;

  ripple_step_wait u_wait (
    .Ck       (Ck),
    .reset_   (reset_),
    .load     (wait_load),
    .load_val (wait_val),
    .count    (wait_cnt),
    .zero     (wait_zero)
  );

  // State register and registered counter-side outputs.
  always_ff @(posedge Ck or negedge reset_) begin
    if (!reset_) begin
      state    <= ST_IDLE;
      t_en     <= 1'b0;
      cnt_clr_ <= 1'b0;
    end else begin
      state    <= state_d;
      t_en     <= (state_d == ST_PULSE);
      cnt_clr_ <= cnt_clr_d;
    end
  end

  // Next-state logic, wait-timer control and completion decision.
  always_comb begin
    state_d   = state;
    wait_load = 1'b0;
    wait_val  = '0;
    cnt_clr_d = 1'b1;
    finish    = 1'b0;
    err_set   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_CLEAR;
          wait_load = 1'b1;
          wait_val  = CLR_LD;
          cnt_clr_d = 1'b0;
        end
      end
      ST_CLEAR: begin
        if (wait_cnt > 4'd1) begin
          cnt_clr_d = 1'b0;
        end
        if (tc_q == '0) begin
          if (wait_cnt <= 4'd1) begin
            state_d = ST_CHECK;
          end
        end else if (wait_zero) begin
          state_d = ST_PULSE;
        end
      end
      ST_PULSE: begin
        state_d   = ST_SETTLE;
        wait_load = 1'b1;
        wait_val  = SETTLE_LD;
      end
      ST_SETTLE: begin
        if (wait_cnt <= 4'd1) begin
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
`ifdef RIPPLE_STEP_CTRL_SHADOW_CHECK_EN
        if (q != step) begin
          state_d = ST_DONE;
          finish  = 1'b1;
          err_set = 1'b1;
        end else if (q == tc_q) begin
          state_d = ST_DONE;
          finish  = 1'b1;
        end else begin
          state_d = ST_PULSE;
        end
`else
        if (q == tc_q) begin
          state_d = ST_DONE;
          finish  = 1'b1;
        end else if (step == tc_q) begin
          state_d = ST_DONE;
          finish  = 1'b1;
          err_set = 1'b1;
        end else begin
          state_d = ST_PULSE;
        end
`endif
      end
      ST_DONE: begin
        if (ack) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Terminal count latch and step counter.
  always_ff @(posedge Ck or negedge reset_) begin
    if (!reset_) begin
      tc_q <= '0;
      step <= '0;
    end else begin
      if (state == ST_IDLE && start) begin
        tc_q <= tc;
      end
      if (state == ST_CLEAR) begin
        step <= '0;
      end else if (state == ST_PULSE) begin
        step <= step + 1'b1;
      end
    end
  end

  // Result capture: settled count and error flag.
  always_ff @(posedge Ck or negedge reset_) begin
    if (!reset_) begin
      count_out <= '0;
      err       <= 1'b0;
    end else if (finish) begin
      count_out <= q;
      err       <= err_set;
    end else if (state == ST_DONE && ack) begin
      err       <= 1'b0;
    end
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_ripple_step_ctrl.sv
// Directed bench for ripple_step_ctrl with a behavioural ripple counter.
// The counter model can drop its second pulse after a clear.
module tb_ripple_step_ctrl;

  logic       ck = 1'b0;
  logic       reset_ = 1'b0;
  logic       start = 1'b0;
  logic [3:0] tc = '0;
  logic       ack = 1'b0;
  logic [3:0] q;
  logic       t_en;
  logic       cnt_clr_;
  logic       busy;
  logic       done;
  logic       err;
  logic [3:0] count_out;

  int checks = 0;
  int errors = 0;

  logic [3:0] q_model = '0;
  int         model_steps = 0;
  int         pulse_total = 0;
  bit         drop_second = 1'b0;

  assign q = q_model;

  ripple_step_ctrl dut (
    .Ck        (ck),
    .reset_    (reset_),
    .start     (start),
    .tc        (tc),
    .ack       (ack),
    .q         (q),
    .t_en      (t_en),
    .cnt_clr_  (cnt_clr_),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .count_out (count_out)
  );

  always #5 ck = ~ck;

  // Counter model: async clear, counts on negedge while T is high.
  always @(negedge ck or negedge cnt_clr_) begin
    if (!cnt_clr_) begin
      q_model     <= '0;
      model_steps <= 0;
    end else if (t_en) begin
      pulse_total <= pulse_total + 1;
      model_steps <= model_steps + 1;
      if (!(drop_second && model_steps == 1))
        q_model <= q_model + 4'd1;
    end
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic tick;
    @(posedge ck);
    #1;
  endtask

  // One request: start, wait for done, check result, then acknowledge.
  task automatic applyStimulus(input string name, input logic [3:0] tc_val,
                               input bit noise, input bit hold_ack,
                               input int exp_lat, input int exp_pulses,
                               input int exp_count, input int exp_err);
    int p0;
    int cycles;
    p0    = pulse_total;
    start = 1'b1;
    tc    = tc_val;
    ack   = hold_ack;
    tick();
    start  = 1'b0;
    cycles = 0;
    while (done !== 1'b1 && cycles < 200) begin
      if (noise && cycles >= 1 && cycles <= 6) begin
        start = cycles[0];
        tc    = 4'd7;
        ack   = (cycles == 4);
      end else if (noise) begin
        start = 1'b0;
        ack   = 1'b0;
      end
      tick();
      cycles++;
    end
    checkOutput({name, "_latency"}, cycles, exp_lat);
    checkOutput({name, "_pulses"}, pulse_total - p0, exp_pulses);
    checkOutput({name, "_count"}, int'(count_out), exp_count);
    checkOutput({name, "_err"}, int'(err), exp_err);
    checkOutput({name, "_busy"}, int'(busy), 1);
    if (!hold_ack) ack = 1'b1;
    tick();
    ack = 1'b0;
    checkOutput({name, "_done_after_ack"}, int'(done), 0);
    checkOutput({name, "_busy_after_ack"}, int'(busy), 0);
    checkOutput({name, "_err_after_ack"}, int'(err), 0);
  endtask

  initial begin
    $display("[TB] ripple_step_ctrl directed test");
    #2;
    checkOutput("rst_t_en", int'(t_en), 0);
    checkOutput("rst_cnt_clr", int'(cnt_clr_), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_err", int'(err), 0);
    checkOutput("rst_count_out", int'(count_out), 0);
    tick();
    reset_ = 1'b1;
    tick();
    checkOutput("rel_cnt_clr", int'(cnt_clr_), 1);
    checkOutput("rel_q", int'(q), 0);
    tick();

    applyStimulus("tc3", 4'd3, 1'b0, 1'b0, 15, 3, 3, 0);
    applyStimulus("tc0", 4'd0, 1'b0, 1'b0, 3, 0, 0, 0);
    applyStimulus("tc15", 4'd15, 1'b0, 1'b0, 63, 15, 15, 0);
    applyStimulus("tc2", 4'd2, 1'b0, 1'b0, 11, 2, 2, 0);
    applyStimulus("noise", 4'd3, 1'b1, 1'b0, 15, 3, 3, 0);
    applyStimulus("ackheld", 4'd1, 1'b0, 1'b1, 7, 1, 1, 0);

    drop_second = 1'b1;
`ifdef RIPPLE_STEP_CTRL_SHADOW_CHECK_EN
    applyStimulus("drop", 4'd4, 1'b0, 1'b0, 11, 2, 1, 1);
`else
    applyStimulus("drop", 4'd4, 1'b0, 1'b0, 19, 4, 3, 1);
`endif
    drop_second = 1'b0;

    // Reset in the middle of a long run.
    start = 1'b1;
    tc    = 4'd9;
    tick();
    start = 1'b0;
    repeat (10) tick();
    checkOutput("mid_busy_before", int'(busy), 1);
    reset_ = 1'b0;
    #1;
    checkOutput("mid_t_en", int'(t_en), 0);
    checkOutput("mid_cnt_clr", int'(cnt_clr_), 0);
    checkOutput("mid_busy", int'(busy), 0);
    checkOutput("mid_done", int'(done), 0);
    repeat (3) tick();
    reset_ = 1'b1;
    tick();
    checkOutput("mid_rel_cnt_clr", int'(cnt_clr_), 1);
    checkOutput("mid_rel_q", int'(q), 0);
    checkOutput("mid_rel_busy", int'(busy), 0);
    checkOutput("mid_rel_done", int'(done), 0);
    tick();
    applyStimulus("after_rst", 4'd2, 1'b0, 1'b0, 11, 2, 2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
